// File: rtl/pred_sched.sv
// Round-robin scheduler for four clients, each with a 2-bit saturating outcome
// predictor; reports the prediction issued per grant and keeps hit/total statistics.
module pred_sched #(
  parameter int         CNT_W   = 8,
  parameter logic [1:0] INIT_ST = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [3:0]       req,
  input  logic [3:0]       act,
  output logic [3:0]       gnt,
  output logic             pred_valid,
  output logic             pred,
  output logic             match,
  output logic [1:0]       pred_id,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] tot_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       r_state [4];
  logic [1:0]       r_ptr;
  logic             r_predValid;
  logic             r_pred;
  logic             r_match;
  logic [1:0]       r_predId;
  logic [CNT_W-1:0] r_hitCnt;
  logic [CNT_W-1:0] r_totCnt;

  logic       w_gntValid;
  logic [1:0] w_gntIdx;
  logic [1:0] w_cand;
  logic [1:0] w_oldSt;
  logic [1:0] w_newSt;
  logic       w_act;
  logic       w_pred;
  logic       w_match;

  // Search starts at the pointer and wraps; reset and clear suppress any grant.
  always_comb begin
    w_gntValid = 1'b0;
    w_gntIdx   = 2'd0;
    w_cand     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_gntValid && req[w_cand]) begin
        w_gntValid = 1'b1;
        w_gntIdx   = w_cand;
      end
    end
    if (!rst || clr) begin
      w_gntValid = 1'b0;
    end
  end

  assign gnt = w_gntValid ? (4'b0001 << w_gntIdx) : 4'b0000;

  always_comb begin
    w_oldSt = r_state[w_gntIdx];
    w_act   = act[w_gntIdx];
    w_pred  = w_oldSt[1];
    w_match = (w_pred == w_act);
    w_newSt = w_oldSt;
    if (w_act) begin
      if (w_oldSt != 2'b11) begin
        w_newSt = w_oldSt + 2'd1;
      end
    end else begin
      if (w_oldSt != 2'b00) begin
        w_newSt = w_oldSt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= INIT_ST;
      end
      r_ptr       <= 2'd0;
      r_predValid <= 1'b0;
      r_pred      <= 1'b0;
      r_match     <= 1'b0;
      r_predId    <= 2'd0;
      r_hitCnt    <= '0;
      r_totCnt    <= '0;
    end else if (clr) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= INIT_ST;
      end
      r_ptr       <= 2'd0;
      r_predValid <= 1'b0;
      r_hitCnt    <= '0;
      r_totCnt    <= '0;
    end else if (w_gntValid) begin
      r_state[w_gntIdx] <= w_newSt;
      r_ptr             <= w_gntIdx + 2'd1;
      r_predValid       <= 1'b1;
      r_pred            <= w_pred;
      r_match           <= w_match;
      r_predId          <= w_gntIdx;
      if (r_totCnt != CNT_MAX) begin
        r_totCnt <= r_totCnt + 1'b1;
      end
      if (w_match && (r_hitCnt != CNT_MAX)) begin
        r_hitCnt <= r_hitCnt + 1'b1;
      end
    end else begin
      r_predValid <= 1'b0;
    end
  end

  assign pred_valid = r_predValid;
  assign pred       = r_pred;
  assign match      = r_match;
  assign pred_id    = r_predId;
  assign hit_cnt    = r_hitCnt;
  assign tot_cnt    = r_totCnt;

endmodule
